// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART serial transmitter; parity frame support selected by UART_TX_PARITY_EN
module uart_tx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [4:0]            prescale,
    output logic                  TX_OUT,
    output logic                  busy
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t                state, state_n;
    logic [4:0]            cnt, cnt_n;
    logic [IDX_W-1:0]      idx, idx_n;
    logic [DATA_WIDTH-1:0] data_r, data_n;
    logic [4:0]            presc_r, presc_n;
    logic                  tx_n, busy_n;
    logic [4:0]            cnt_last;
    logic                  bit_done;

`ifdef UART_TX_PARITY_EN
    logic par_en_r, par_en_n;
    logic par_typ_r, par_typ_n;
    logic par_bit;

    // Parity covers the latched word; odd parity inverts the XOR
    assign par_bit = (^data_r) ^ par_typ_r;
`else
    logic unused_par_cfg;
    assign unused_par_cfg = PAR_EN ^ PAR_TYP;
`endif

    // A latched prescale of zero behaves as a one-cycle bit period
    assign cnt_last = (presc_r == 5'd0) ? 5'd0 : (presc_r - 5'd1);
    assign bit_done = (cnt == cnt_last);

    // Next-state, next-counter and registered-output computation
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        idx_n     = idx;
        data_n    = data_r;
        presc_n   = presc_r;
`ifdef UART_TX_PARITY_EN
        par_en_n  = par_en_r;
        par_typ_n = par_typ_r;
`endif
        tx_n      = 1'b1;
        busy_n    = 1'b0;

        case (state)
            IDLE: begin
                cnt_n = 5'd0;
                idx_n = '0;
                if (DATA_VALID) begin
                    data_n    = P_DATA;
                    presc_n   = prescale;
`ifdef UART_TX_PARITY_EN
                    par_en_n  = PAR_EN;
                    par_typ_n = PAR_TYP;
`endif
                    state_n   = START;
                end
            end
            START: begin
                if (bit_done) begin
                    cnt_n   = 5'd0;
                    idx_n   = '0;
                    state_n = DATA;
                end else begin
                    cnt_n = cnt + 5'd1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    cnt_n = 5'd0;
                    if (idx == LAST_IDX) begin
                        state_n = STOP;
`ifdef UART_TX_PARITY_EN
                        if (par_en_r) begin
                            state_n = PARITY;
                        end
`endif
                    end else begin
                        idx_n = idx + IDX_W'(1);
                    end
                end else begin
                    cnt_n = cnt + 5'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    cnt_n   = 5'd0;
                    state_n = STOP;
                end else begin
                    cnt_n = cnt + 5'd1;
                end
            end
`endif
            STOP: begin
                if (bit_done) begin
                    cnt_n   = 5'd0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + 5'd1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = 5'd0;
                idx_n   = '0;
            end
        endcase

        // Outputs follow the state being entered so they are registered with it
        case (state_n)
            START: begin
                tx_n   = 1'b0;
                busy_n = 1'b1;
            end
            DATA: begin
                tx_n   = data_n[idx_n];
                busy_n = 1'b1;
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                tx_n   = par_bit;
                busy_n = 1'b1;
            end
`endif
            STOP: begin
                tx_n   = 1'b1;
                busy_n = 1'b1;
            end
            default: begin
                tx_n   = 1'b1;
                busy_n = 1'b0;
            end
        endcase
    end

    // State, frame context and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 5'd0;
            idx       <= '0;
            data_r    <= '0;
            presc_r   <= 5'd0;
`ifdef UART_TX_PARITY_EN
            par_en_r  <= 1'b0;
            par_typ_r <= 1'b0;
`endif
            TX_OUT    <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            data_r    <= data_n;
            presc_r   <= presc_n;
`ifdef UART_TX_PARITY_EN
            par_en_r  <= par_en_n;
            par_typ_r <= par_typ_n;
`endif
            TX_OUT    <= tx_n;
            busy      <= busy_n;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx against a frame-level waveform model
module tb_uart_tx;

    localparam int DW = 8;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR_BUILD = 1'b1;
`else
    localparam bit PAR_BUILD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] P_DATA = '0;
    logic          DATA_VALID = 1'b0;
    logic          PAR_EN = 1'b0;
    logic          PAR_TYP = 1'b0;
    logic [4:0]    prescale = 5'd0;
    logic          TX_OUT;
    logic          busy;

    int checks = 0;
    int errors = 0;

    bit exp_tx[$];
    bit exp_busy[$];
    int dv_lo = -1;
    int dv_hi = -2;
    bit scramble = 1'b1;

    uart_tx #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .prescale   (prescale),
        .TX_OUT     (TX_OUT),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check_bit(input string tag, input int cyc, input logic act, input logic exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d: got %b expected %b", tag, cyc, act, exp);
        end
    endtask

    // Expected line waveform: start, data LSB first, optional parity, stop; each bit P cycles
    task automatic add_frame(input logic [DW-1:0] d, input bit pe, input bit pt, input int ps);
        bit fr[$];
        int p;
        p = (ps == 0) ? 1 : ps;
        fr.push_back(1'b0);
        for (int i = 0; i < DW; i++) fr.push_back(d[i]);
        if (PAR_BUILD && pe) fr.push_back((^d) ^ pt);
        fr.push_back(1'b1);
        foreach (fr[b]) begin
            for (int c = 0; c < p; c++) begin
                exp_tx.push_back(fr[b]);
                exp_busy.push_back(1'b1);
            end
        end
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) begin
            exp_tx.push_back(1'b1);
            exp_busy.push_back(1'b0);
        end
    endtask

    task automatic start_frame(input logic [DW-1:0] d, input bit pe, input bit pt, input logic [4:0] ps);
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        prescale   = ps;
        DATA_VALID = 1'b1;
        @(negedge clk);
    endtask

    // Compare one sample per cycle at the falling edge, then drive the next cycle's inputs
    task automatic run_check(input string tag);
        for (int i = 0; i < exp_tx.size(); i++) begin
            check_bit({tag, ".tx"}, i, TX_OUT, exp_tx[i]);
            check_bit({tag, ".busy"}, i, busy, exp_busy[i]);
            DATA_VALID = (i >= dv_lo) && (i <= dv_hi);
            if (scramble) begin
                if (DATA_VALID) begin
                    P_DATA = '1;
                end else begin
                    P_DATA   = DW'($urandom);
                    prescale = 5'($urandom);
                    PAR_EN   = 1'($urandom);
                    PAR_TYP  = 1'($urandom);
                end
            end
            @(negedge clk);
        end
        exp_tx.delete();
        exp_busy.delete();
    endtask

    initial begin
        logic [DW-1:0] d;
        bit            pe;
        bit            pt;
        int            ps;

        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_bit("reset.tx", 0, TX_OUT, 1'b1);
        check_bit("reset.busy", 0, busy, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check_bit("idle.tx", 0, TX_OUT, 1'b1);
        check_bit("idle.busy", 0, busy, 1'b0);

        add_frame(8'hA5, 1'b1, 1'b0, 8);
        add_idle(4);
        start_frame(8'hA5, 1'b1, 1'b0, 5'd8);
        run_check("a5_even");

        add_frame(8'hA5, 1'b1, 1'b1, 8);
        add_idle(4);
        start_frame(8'hA5, 1'b1, 1'b1, 5'd8);
        run_check("a5_odd");

        add_frame(8'h00, 1'b0, 1'b0, 16);
        add_idle(4);
        start_frame(8'h00, 1'b0, 1'b0, 5'd16);
        run_check("zero_p16");

        dv_lo = 20;
        dv_hi = 20;
        add_frame(8'h5A, 1'b0, 1'b0, 4);
        add_idle(20);
        start_frame(8'h5A, 1'b0, 1'b0, 5'd4);
        run_check("dv_ignored");
        dv_lo = -1;
        dv_hi = -2;

        add_frame(8'hC3, 1'b0, 1'b0, 4);
        while (exp_tx.size() > 18) begin
            void'(exp_tx.pop_back());
            void'(exp_busy.pop_back());
        end
        start_frame(8'hC3, 1'b0, 1'b0, 5'd4);
        run_check("pre_rst");
        rst = 1'b0;
        @(negedge clk);
        check_bit("mid_rst.tx", 0, TX_OUT, 1'b1);
        check_bit("mid_rst.busy", 0, busy, 1'b0);
        rst = 1'b1;
        add_idle(6);
        run_check("post_rst_idle");
        add_frame(8'hC3, 1'b1, 1'b1, 4);
        add_idle(2);
        start_frame(8'hC3, 1'b1, 1'b1, 5'd4);
        run_check("post_rst_frame");

        scramble = 1'b0;
        dv_lo = 0;
        dv_hi = 40;
        add_frame(8'h3C, 1'b0, 1'b0, 4);
        add_idle(1);
        add_frame(8'h96, 1'b0, 1'b0, 4);
        add_idle(3);
        start_frame(8'h3C, 1'b0, 1'b0, 5'd4);
        P_DATA = 8'h96;
        run_check("back2back");
        dv_lo = -1;
        dv_hi = -2;
        scramble = 1'b1;

        for (int k = 0; k < 9; k++) begin
            d  = DW'($urandom);
            pe = 1'($urandom);
            pt = 1'($urandom);
            if (k == 0)      ps = 0;
            else if (k == 1) ps = 1;
            else if (k == 2) ps = 31;
            else             ps = int'($urandom_range(0, 7));
            add_frame(d, pe, pt, ps);
            add_idle(2);
            start_frame(d, pe, pt, 5'(ps));
            run_check("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
